// File: rtl/sd_cmd_rx_deserializer_if.sv
// Interface between the CMD-line deserializer and the CMD control FSM.
// The master side arms the receiver and drives the synchronised CMD line.
// The slave side (the deserializer) returns the frame and its status flags.
interface sd_cmd_rx_deserializer_if #(
  parameter int LONG_WIDTH = 136
);
  logic                  start_listening_nxt_cycle;
  logic                  response_long;
  logic                  crc_check_en;
  logic                  serial_in;
  logic                  busy;
  logic                  finished;
  logic [LONG_WIDTH-1:0] parallel_out;
  logic                  crc_error;
  logic                  end_bit_error;
  logic                  timeout;

  modport master (
    output start_listening_nxt_cycle, response_long, crc_check_en, serial_in,
    input  busy, finished, parallel_out, crc_error, end_bit_error, timeout
  );

  modport slave (
    input  start_listening_nxt_cycle, response_long, crc_check_en, serial_in,
    output busy, finished, parallel_out, crc_error, end_bit_error, timeout
  );
endinterface

// File: rtl/sd_cmd_rx_deserializer.sv
// SD CMD-line response receiver.
// Waits for a start bit, shifts in a short or long response MSB first, and
// checks the CRC7 and the end bit. It flags a timeout when no start bit
// arrives within TIMEOUT_CYCLES samples. The result and flags are held
// until the next accepted start request.
module sd_cmd_rx_deserializer #(
  parameter int SHORT_WIDTH    = 48,
  parameter int LONG_WIDTH     = 136,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input logic CLK,
  input logic RESET_N,
  sd_cmd_rx_deserializer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_t;

  localparam logic [CNT_W-1:0] SHORT_N   = CNT_W'(SHORT_WIDTH);
  localparam logic [CNT_W-1:0] LONG_N    = CNT_W'(LONG_WIDTH);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SKIP = CNT_W'(8);
  localparam logic [CNT_W-1:0] TAIL_LEN  = CNT_W'(9);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t                state;
  logic                  long_mode;
  logic                  crc_en;
  logic [LONG_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bitcnt;
  logic [CNT_W-1:0]      tocnt;
  logic [6:0]            crc;
  logic                  finished;
  logic [LONG_WIDTH-1:0] parallel_out;
  logic                  crc_error;
  logic                  end_bit_error;
  logic                  timeout;

  logic [CNT_W-1:0]      frame_len;
  logic [CNT_W-1:0]      crc_first;
  logic [CNT_W-1:0]      crc_last;
  logic                  crc_take;
  logic                  crc_fb;
  logic [6:0]            crc_upd;
  logic [LONG_WIDTH-1:0] shreg_shift;

  // Frame geometry for the latched mode, CRC window and next shift/CRC values.
  // bitcnt is the number of bits already received, so the current sample
  // is bit number bitcnt+1 of the frame. The CRC stops 8 bits before the end
  // (7 CRC bits plus the end bit). Long frames skip their 8-bit header.
  always_comb begin
    frame_len   = long_mode ? LONG_N : SHORT_N;
    crc_first   = long_mode ? LONG_SKIP : '0;
    crc_last    = frame_len - TAIL_LEN;
    crc_take    = (bitcnt >= crc_first) && (bitcnt <= crc_last);
    crc_fb      = bus.serial_in ^ crc[6];
    crc_upd     = {crc[5:3], crc[2] ^ crc_fb, crc[1:0], crc_fb};
    shreg_shift = {shreg[LONG_WIDTH-2:0], bus.serial_in};
  end

  // Receiver FSM. A start request overrides every state and restarts cleanly.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      long_mode     <= 1'b0;
      crc_en        <= 1'b0;
      shreg         <= '0;
      bitcnt        <= '0;
      tocnt         <= '0;
      crc           <= '0;
      finished      <= 1'b0;
      parallel_out  <= '0;
      crc_error     <= 1'b0;
      end_bit_error <= 1'b0;
      timeout       <= 1'b0;
    end else if (bus.start_listening_nxt_cycle) begin
      state         <= WAIT_START;
      long_mode     <= bus.response_long;
      crc_en        <= bus.crc_check_en;
      shreg         <= '0;
      bitcnt        <= '0;
      tocnt         <= '0;
      crc           <= '0;
      finished      <= 1'b0;
      parallel_out  <= '0;
      crc_error     <= 1'b0;
      end_bit_error <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          finished <= 1'b0;
        end
        WAIT_START: begin
          if (!bus.serial_in) begin
            // The start bit lands in the LSB. It reaches position N-1
            // after the remaining N-1 shifts.
            shreg  <= {{(LONG_WIDTH-1){1'b0}}, bus.serial_in};
            bitcnt <= ONE;
            crc    <= '0;
            state  <= RECEIVE;
          end else if (tocnt == TO_LAST) begin
            timeout  <= 1'b1;
            finished <= 1'b1;
            state    <= DONE;
          end else begin
            tocnt <= tocnt + ONE;
          end
        end
        RECEIVE: begin
          shreg  <= shreg_shift;
          bitcnt <= bitcnt + ONE;
          if (crc_take) begin
            crc <= crc_upd;
          end
          if (bitcnt == frame_len - ONE) begin
            // This sample is the end bit. shreg[6:0] holds the received CRC.
            parallel_out  <= shreg_shift;
            crc_error     <= crc_en && (shreg[6:0] != crc);
            end_bit_error <= !bus.serial_in;
            finished      <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          finished <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = (state == WAIT_START) || (state == RECEIVE);
  assign bus.finished      = finished;
  assign bus.parallel_out  = parallel_out;
  assign bus.crc_error     = crc_error;
  assign bus.end_bit_error = end_bit_error;
  assign bus.timeout       = timeout;
endmodule

// File: tb/tb_sd_cmd_rx_deserializer.sv
// Self-checking bench for the SD CMD-line response receiver.
// Expected results are queued when a frame is driven. They are popped and
// compared when finished rises.
`timescale 1ns/1ps
module tb_sd_cmd_rx_deserializer;
  localparam int LW = 136;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_cmd_rx_deserializer_if #(.LONG_WIDTH(LW)) bus();

  sd_cmd_rx_deserializer #(
    .SHORT_WIDTH(48), .LONG_WIDTH(LW), .TIMEOUT_CYCLES(64), .CNT_W(8)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [LW-1:0] data;
    logic          crc_e;
    logic          end_e;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  int fin_count = 0;

  // Count cycles with finished high, sampled at the rising edge before any update.
  always @(posedge clk) if (bus.finished === 1'b1) fin_count++;

  localparam logic [LW-1:0] CMD0  = 136'h400000000095;
  localparam logic [LW-1:0] CMD17 = 136'h510000000054;

  function automatic logic [6:0] crc7(input logic [LW-1:0] f, input int hi, input int lo);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = hi; i >= lo; i--) begin
      fb = f[i] ^ c[6];
      c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic exp_t mk(input logic [LW-1:0] d, input logic ce, input logic ee, input logic t);
    exp_t e;
    e.data = d; e.crc_e = ce; e.end_e = ee; e.to = t;
    return e;
  endfunction

  // Called at a falling edge. The request is sampled at the next rising edge.
  // The mode inputs are then inverted to show they are ignored afterwards.
  task automatic start_req(input logic lng, input logic crce);
    bus.start_listening_nxt_cycle = 1'b1;
    bus.response_long = lng;
    bus.crc_check_en = crce;
    bus.serial_in = 1'b1;
    @(negedge clk);
    bus.start_listening_nxt_cycle = 1'b0;
    bus.response_long = ~lng;
    bus.crc_check_en = ~crce;
  endtask

  task automatic drive_bits(input logic [LW-1:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.serial_in = f[i];
      @(negedge clk);
    end
    bus.serial_in = 1'b1;
  endtask

  // Expect finished at the current falling edge, then compare with the queue head.
  task automatic collect(input string name);
    exp_t e;
    int waited;
    waited = 0;
    while (bus.finished !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.finished !== 1'b1 || waited != 0) begin
      fails++;
      $display("FAIL %s latency: finished=%b after %0d extra cycles, required 1 after 0", name, bus.finished, waited);
    end
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: queue empty, required one entry", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (bus.parallel_out !== e.data) begin
      fails++;
      $display("FAIL %s parallel_out: got %h, required %h", name, bus.parallel_out, e.data);
    end
    checks++;
    if (bus.crc_error !== e.crc_e) begin
      fails++;
      $display("FAIL %s crc_error: got %b, required %b", name, bus.crc_error, e.crc_e);
    end
    checks++;
    if (bus.end_bit_error !== e.end_e) begin
      fails++;
      $display("FAIL %s end_bit_error: got %b, required %b", name, bus.end_bit_error, e.end_e);
    end
    checks++;
    if (bus.timeout !== e.to) begin
      fails++;
      $display("FAIL %s timeout: got %b, required %b", name, bus.timeout, e.to);
    end
    $display("%s: parallel_out=%h crc_error=%b end_bit_error=%b timeout=%b",
             name, bus.parallel_out, bus.crc_error, bus.end_bit_error, bus.timeout);
    @(negedge clk);
    checks++;
    if (bus.finished !== 1'b0) begin
      fails++;
      $display("FAIL %s pulse width: finished=%b one cycle later, required 0", name, bus.finished);
    end
  endtask

  task automatic send_frame(input string name, input logic [LW-1:0] f, input int n,
                            input logic lng, input logic crce, input int idle, input exp_t e);
    sb.push_back(e);
    start_req(lng, crce);
    repeat (idle) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy while waiting: got %b, required 1", name, bus.busy);
    end
    drive_bits(f, n - 1, 0);
    collect(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.finished, bus.crc_error, bus.end_bit_error, bus.timeout} !== 5'b0 ||
        bus.parallel_out !== '0) begin
      fails++;
      $display("FAIL reset outputs: busy/fin/crc/end/to=%b%b%b%b%b data=%h, required all 0",
               bus.busy, bus.finished, bus.crc_error, bus.end_bit_error, bus.timeout, bus.parallel_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_short();
    send_frame("cmd0", CMD0, 48, 1'b0, 1'b1, 3, mk(CMD0, 1'b0, 1'b0, 1'b0));
    send_frame("cmd0_bit10", CMD0 ^ (136'd1 << 10), 48, 1'b0, 1'b1, 2,
               mk(CMD0 ^ (136'd1 << 10), 1'b1, 1'b0, 1'b0));
    send_frame("cmd17_endbit", CMD17, 48, 1'b0, 1'b1, 1, mk(CMD17, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic test_timeout();
    bit early;
    early = 1'b0;
    sb.push_back(mk('0, 1'b0, 1'b0, 1'b1));
    start_req(1'b0, 1'b1);
    bus.serial_in = 1'b1;
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      if (bus.finished === 1'b1) early = 1'b1;
    end
    checks++;
    if (early) begin
      fails++;
      $display("FAIL timeout early: finished rose before sample 64, required none");
    end
    @(negedge clk);
    collect("timeout");
  endtask

  task automatic test_long();
    logic [LW-1:0] f;
    logic [LW-1:0] bad;
    f = '0;
    f[135:128] = 8'h3F;
    for (int i = 8; i < 128; i++) f[i] = 1'($urandom_range(0, 1));
    f[7:1] = crc7(f, 127, 8);
    f[0] = 1'b1;
    bad = f ^ (136'd1 << 3);
    send_frame("r2_good", f, 136, 1'b1, 1'b1, 2, mk(f, 1'b0, 1'b0, 1'b0));
    send_frame("r2_badcrc_chk", bad, 136, 1'b1, 1'b1, 1, mk(bad, 1'b1, 1'b0, 1'b0));
    send_frame("r2_badcrc_nochk", bad, 136, 1'b1, 1'b0, 1, mk(bad, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic test_reset_mid();
    int fc;
    start_req(1'b0, 1'b1);
    drive_bits(CMD0, 47, 28);
    fc = fin_count;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.finished, bus.crc_error, bus.end_bit_error, bus.timeout} !== 5'b0 ||
        bus.parallel_out !== '0) begin
      fails++;
      $display("FAIL reset_mid outputs: busy/fin/crc/end/to=%b%b%b%b%b data=%h, required all 0",
               bus.busy, bus.finished, bus.crc_error, bus.end_bit_error, bus.timeout, bus.parallel_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_bits(CMD0, 27, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (fin_count != fc) begin
      fails++;
      $display("FAIL reset_mid no pulse: %0d finished cycles, required 0", fin_count - fc);
    end
    send_frame("after_reset", CMD0, 48, 1'b0, 1'b1, 2, mk(CMD0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic test_restart();
    int fc;
    fc = fin_count;
    start_req(1'b1, 1'b0);
    drive_bits(CMD17, 47, 18);
    send_frame("restart", CMD0, 48, 1'b0, 1'b1, 2, mk(CMD0, 1'b0, 1'b0, 1'b0));
    checks++;
    if (fin_count != fc + 1) begin
      fails++;
      $display("FAIL restart pulses: %0d finished cycles, required 1", fin_count - fc);
    end
  endtask

  initial begin
    bus.start_listening_nxt_cycle = 1'b0;
    bus.response_long = 1'b0;
    bus.crc_check_en = 1'b0;
    bus.serial_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_short();
    test_timeout();
    test_long();
    test_reset_mid();
    test_restart();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
